// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: lane geometry, counter
// width and the responder's FSM state encoding.
package mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int WORD_W    = 32;
  localparam int LANE_W    = WORD_W / NUM_LANES;
  localparam int CNT_W     = 4;
  localparam int MAX_WAIT  = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/word_ram.sv
// Synchronous single-port word RAM with per-byte write enables and a
// one-cycle registered read. A read issued together with a write returns
// the word as it stood before that edge.
module word_ram
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  // Byte-lane write and registered read, both gated by the access enable
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we[i]) begin
          mem[waddr][LANE_W*i +: LANE_W] <= wdata[LANE_W*i +: LANE_W];
        end
      end
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port. Captures a word request,
// holds it for WAIT_CYCLES wait states, performs the RAM access on the edge
// that enters RESP and answers with a one-cycle ack carrying rdata/err.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [3:0]  wren,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_wait_range_check
    $error("data_mem_responder: WAIT_CYCLES=%0d outside 0..%0d", WAIT_CYCLES, MAX_WAIT);
  end

  // Counter load value on acceptance; unused when there are no wait states.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   word_q;
  logic [NUM_LANES-1:0]    wren_q;
  logic [WORD_W-1:0]       wdata_q;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   src_word;
  logic [NUM_LANES-1:0]    src_wren;
  logic [WORD_W-1:0]       src_wdata;
  logic                    src_err;
  logic                    enter_resp;
  logic                    ram_en;
  logic [NUM_LANES-1:0]    ram_we;
  logic [WORD_W-1:0]       ram_rdata;

  // Misaligned or beyond the RAM's byte range.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wait counter and request capture; later input changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      word_q  <= '0;
      wren_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt     <= CNT_INIT;
            word_q  <= addr[ADDR_WIDTH+1:2];
            wren_q  <= wren;
            wdata_q <= wdata;
            err_q   <= addr_err(addr);
          end
        end
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // RAM access source: with zero wait states the access happens on the
  // sampling edge itself, before the capture registers hold the request.
  always_comb begin
    src_word   = word_q;
    src_wren   = wren_q;
    src_wdata  = wdata_q;
    src_err    = err_q;
    if (state == IDLE) begin
      src_word  = addr[ADDR_WIDTH+1:2];
      src_wren  = wren;
      src_wdata = wdata;
      src_err   = addr_err(addr);
    end
    enter_resp = (state_next == RESP) && (state != RESP);
    ram_en     = enter_resp && !src_err && rst;
    ram_we     = ram_en ? src_wren : '0;
  end

  word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .waddr (src_word),
    .raddr (src_word),
    .wdata (src_wdata),
    .rdata (ram_rdata)
  );

  // Response outputs; all zero outside the ack cycle
  always_comb begin
    ack   = (state == RESP);
    err   = ack && err_q;
    rdata = '0;
    if (ack && !err_q && (wren_q == '0)) rdata = ram_rdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states and one
// with none, directed scenarios followed by random traffic against a
// word-array reference model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_a, req_b;
  logic [31:0] addr, wdata;
  logic [3:0]  wren;
  logic        ack_a, err_a, ack_b, err_b;
  logic [31:0] rdata_a, rdata_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [2][16];

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .req(req_a), .addr(addr), .wren(wren), .wdata(wdata),
    .ack(ack_a), .rdata(rdata_a), .err(err_a)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req_b), .addr(addr), .wren(wren), .wdata(wdata),
    .ack(ack_b), .rdata(rdata_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? ack_a : ack_b;
  endfunction

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? rdata_a : rdata_b;
  endfunction

  function automatic logic err_of(input int sel);
    return (sel == 0) ? err_a : err_b;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One transaction from a negedge: returns ack latency in cycles after the
  // sampling edge (-1 on timeout), response data, and whether ack fell again.
  task automatic txn(input int sel, input logic [31:0] a, input logic [3:0] we,
                     input logic [31:0] d, output int lat, output logic [31:0] rd,
                     output logic e, output logic one_shot);
    addr = a; wren = we; wdata = d;
    if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
    @(posedge clk);
    lat = -1; rd = '0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_of(sel)) begin
        lat = n; rd = rdata_of(sel); e = err_of(sel);
        break;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    one_shot = !ack_of(sel);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; addr = '0; wren = '0; wdata = '0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({ack_a, err_a, rdata_a, ack_b, err_b, rdata_b} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got a=%b/%b/%h b=%b/%b/%h want all zero",
                 ack_a, err_a, rdata_a, ack_b, err_b, rdata_b);
      end
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({ack_a, err_a, rdata_a, ack_b, err_b, rdata_b} !== '0) begin
        bad++;
        $display("FAIL idle_outputs: got a=%b/%b/%h b=%b/%b/%h want all zero",
                 ack_a, err_a, rdata_a, ack_b, err_b, rdata_b);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic e, os;
    txn(0, 32'h10, 4'hF, 32'hCAFEBABE, lat, rd, e, os);
    total++;
    if ({lat, e, rd, os} !== {32'd3, 1'b0, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL write_full: got lat=%0d err=%b rdata=%h oneshot=%b want 3 0 0 1", lat, e, rd, os);
    end
    txn(0, 32'h10, 4'h0, 32'h0, lat, rd, e, os);
    total++;
    if ({lat, e, rd, os} !== {32'd3, 1'b0, 32'hCAFEBABE, 1'b1}) begin
      bad++;
      $display("FAIL read_full: got lat=%0d err=%b rdata=%h oneshot=%b want 3 0 cafebabe 1", lat, e, rd, os);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic e, os;
    txn(0, 32'h10, 4'b0101, 32'h11223344, lat, rd, e, os);
    txn(0, 32'h10, 4'h0, 32'h0, lat, rd, e, os);
    total++;
    if (rd !== 32'hCA22BA44 || e !== 1'b0) begin
      bad++;
      $display("FAIL byte_lanes: got rdata=%h err=%b want ca22ba44 0", rd, e);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic e, os;
    txn(0, 32'h0, 4'hF, 32'h5A5A1234, lat, rd, e, os);
    txn(0, 32'h13, 4'h0, 32'h0, lat, rd, e, os);
    total++;
    if ({lat, e, rd} !== {32'd3, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL err_misaligned: got lat=%0d err=%b rdata=%h want 3 1 0", lat, e, rd);
    end
    txn(0, 32'h400, 4'hF, 32'hFFFFFFFF, lat, rd, e, os);
    total++;
    if ({lat, e, rd} !== {32'd3, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL err_range: got lat=%0d err=%b rdata=%h want 3 1 0", lat, e, rd);
    end
    txn(0, 32'h0, 4'h0, 32'h0, lat, rd, e, os);
    total++;
    if (rd !== 32'h5A5A1234 || e !== 1'b0) begin
      bad++;
      $display("FAIL err_no_write: got rdata=%h err=%b want 5a5a1234 0", rd, e);
    end
  endtask

  task automatic test_reset_mid();
    int lat; int acks; logic [31:0] rd; logic e, os;
    txn(0, 32'h20, 4'hF, 32'h0, lat, rd, e, os);
    addr = 32'h20; wren = 4'hF; wdata = 32'hDEADBEEF; req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_a = 1'b0; rst = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL abort_wait_ack: got %0d acks want 0", acks);
    end
    txn(0, 32'h20, 4'h0, 32'h0, lat, rd, e, os);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL abort_wait_nowrite: got rdata=%h want 0", rd);
    end
    // reset inside the ack cycle: ack drops at once, write stays committed
    addr = 32'h24; wren = 4'hF; wdata = 32'h600DF00D; req_a = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 10 && !ack_a; n++) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({ack_a, err_a, rdata_a} !== '0) begin
      bad++;
      $display("FAIL reset_in_resp: got ack=%b err=%b rdata=%h want 0 0 0", ack_a, err_a, rdata_a);
    end
    @(negedge clk);
    req_a = 1'b0; rst = 1'b1;
    @(negedge clk);
    txn(0, 32'h24, 4'h0, 32'h0, lat, rd, e, os);
    total++;
    if (rd !== 32'h600DF00D) begin
      bad++;
      $display("FAIL resp_write_kept: got rdata=%h want 600df00d", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat; int acks; logic [31:0] rd; logic e, os;
    for (int i = 2; i <= 3; i++) begin
      model[1][i] = $urandom;
      txn(1, 32'(i * 4), 4'hF, model[1][i], lat, rd, e, os);
    end
    addr = 32'h8; wren = 4'h0; req_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ack_b !== 1'b1 || rdata_b !== model[1][2]) begin
      bad++;
      $display("FAIL b2b_first: got ack=%b rdata=%h want 1 %h", ack_b, rdata_b, model[1][2]);
    end
    addr = 32'hC;
    @(negedge clk);
    total++;
    if (ack_b !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap: got ack=%b want 0", ack_b);
    end
    @(negedge clk);
    total++;
    if (ack_b !== 1'b1 || rdata_b !== model[1][3]) begin
      bad++;
      $display("FAIL b2b_second: got ack=%b rdata=%h want 1 %h", ack_b, rdata_b, model[1][3]);
    end
    req_b = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_b) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL b2b_extra_ack: got %0d extra acks want 0", acks);
    end
  endtask

  task automatic test_random();
    int lat; int kind; int idx; int exp_lat;
    logic [31:0] a, d, rd, exp_rd;
    logic [3:0] we;
    logic e, os, exp_err;
    for (int sel = 0; sel < 2; sel++) begin
      exp_lat = (sel == 0) ? 3 : 1;
      for (int i = 0; i < 16; i++) begin
        model[sel][i] = $urandom;
        txn(sel, 32'(i * 4), 4'hF, model[sel][i], lat, rd, e, os);
        total++;
        if (lat !== exp_lat || e !== 1'b0) begin
          bad++;
          $display("FAIL prime[%0d]: got lat=%0d err=%b want %0d 0", sel, lat, e, exp_lat);
        end
      end
      for (int t = 0; t < 40; t++) begin
        kind = $urandom_range(0, 7);
        idx  = $urandom_range(0, 15);
        a    = 32'(idx * 4);
        if (kind == 0) a = a + 32'($urandom_range(1, 3));
        if (kind == 1) a = a | (32'h1 << $urandom_range(10, 31));
        we   = (kind >= 5) ? 4'h0 : 4'($urandom);
        d    = $urandom;
        exp_err = (a % 4 != 0) || (a >= 32'd1024);
        exp_rd  = (exp_err || we != 4'h0) ? 32'h0 : model[sel][idx];
        if (!exp_err) model[sel][idx] = merge(model[sel][idx], d, we);
        txn(sel, a, we, d, lat, rd, e, os);
        total++;
        if (lat !== exp_lat || e !== exp_err || rd !== exp_rd || os !== 1'b1) begin
          bad++;
          $display("FAIL rand[%0d.%0d] a=%h we=%h: got lat=%0d err=%b rdata=%h oneshot=%b want %0d %b %h 1",
                   sel, t, a, we, lat, e, rd, os, exp_lat, exp_err, exp_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
